id_exe_reg: RTL and testbench

ID/EXE pipeline register for the five-stage core: captures the decode-stage control bundle (ALU_Ctrl_op, Imm_type-expanded immediate, select/enable bits) and operands, and presents them to the execute stage one cycle later. It contains the load-use hazard detector. It also inserts bubbles on branch/jump flush and on load-use hazards, holds on external pipeline stall, and counts inserted bubbles for performance monitoring.

---
 rtl/id_exe_if.sv | 73 +++++++
 rtl/id_exe_reg.sv | 135 +++++++++++++
 tb/tb_id_exe_reg.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_exe_if.sv
// ID/EXE bus bundle: decode-stage inputs (id_*) and execute-stage outputs (ex_*).
interface id_exe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              id_valid_i;
    logic [2:0]        id_ALU_Ctrl_op_i;
    logic              id_EXE_pc_sel_i;
    logic              id_ALU_rs2_sel_i;
    logic              id_MEM_rd_sel_i;
    logic              id_DM_read_i;
    logic              id_DM_write_i;
    logic              id_reg_file_write_i;
    logic              id_WB_data_sel_i;
    logic [1:0]        id_branch_signal_i;
    logic [DATA_W-1:0] id_pc_i;
    logic [DATA_W-1:0] id_rs1_data_i;
    logic [DATA_W-1:0] id_rs2_data_i;
    logic [DATA_W-1:0] id_imm_i;
    logic [REG_AW-1:0] id_rs1_addr_i;
    logic [REG_AW-1:0] id_rs2_addr_i;
    logic [REG_AW-1:0] id_rd_addr_i;
    logic [2:0]        id_funct3_i;
    logic [6:0]        id_funct7_i;

    logic              ex_valid_o;
    logic [2:0]        ex_ALU_Ctrl_op_o;
    logic              ex_EXE_pc_sel_o;
    logic              ex_ALU_rs2_sel_o;
    logic              ex_MEM_rd_sel_o;
    logic              ex_DM_read_o;
    logic              ex_DM_write_o;
    logic              ex_reg_file_write_o;
    logic              ex_WB_data_sel_o;
    logic [1:0]        ex_branch_signal_o;
    logic [DATA_W-1:0] ex_pc_o;
    logic [DATA_W-1:0] ex_rs1_data_o;
    logic [DATA_W-1:0] ex_rs2_data_o;
    logic [DATA_W-1:0] ex_imm_o;
    logic [REG_AW-1:0] ex_rs1_addr_o;
    logic [REG_AW-1:0] ex_rs2_addr_o;
    logic [REG_AW-1:0] ex_rd_addr_o;
    logic [2:0]        ex_funct3_o;
    logic [6:0]        ex_funct7_o;

    // Decode stage side: drives the ID bundle, observes the EXE copy.
    modport master (
        output id_valid_i, id_ALU_Ctrl_op_i, id_EXE_pc_sel_i, id_ALU_rs2_sel_i,
               id_MEM_rd_sel_i, id_DM_read_i, id_DM_write_i, id_reg_file_write_i,
               id_WB_data_sel_i, id_branch_signal_i, id_pc_i, id_rs1_data_i,
               id_rs2_data_i, id_imm_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
               id_funct3_i, id_funct7_i,
        input  ex_valid_o, ex_ALU_Ctrl_op_o, ex_EXE_pc_sel_o, ex_ALU_rs2_sel_o,
               ex_MEM_rd_sel_o, ex_DM_read_o, ex_DM_write_o, ex_reg_file_write_o,
               ex_WB_data_sel_o, ex_branch_signal_o, ex_pc_o, ex_rs1_data_o,
               ex_rs2_data_o, ex_imm_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
               ex_funct3_o, ex_funct7_o
    );

    // Pipeline register side: samples the ID bundle, drives the EXE copy.
    modport slave (
        input  id_valid_i, id_ALU_Ctrl_op_i, id_EXE_pc_sel_i, id_ALU_rs2_sel_i,
               id_MEM_rd_sel_i, id_DM_read_i, id_DM_write_i, id_reg_file_write_i,
               id_WB_data_sel_i, id_branch_signal_i, id_pc_i, id_rs1_data_i,
               id_rs2_data_i, id_imm_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
               id_funct3_i, id_funct7_i,
        output ex_valid_o, ex_ALU_Ctrl_op_o, ex_EXE_pc_sel_o, ex_ALU_rs2_sel_o,
               ex_MEM_rd_sel_o, ex_DM_read_o, ex_DM_write_o, ex_reg_file_write_o,
               ex_WB_data_sel_o, ex_branch_signal_o, ex_pc_o, ex_rs1_data_o,
               ex_rs2_data_o, ex_imm_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
               ex_funct3_o, ex_funct7_o
    );
endinterface

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with load-use hazard detection, bubble insertion
// on flush/hazard, hold on external stall, and a saturating bubble counter.
module id_exe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    id_exe_if.slave          bus,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             ld_use_stall_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    typedef struct packed {
        logic              valid;
        logic [2:0]        alu_op;
        logic              exe_pc_sel;
        logic              alu_rs2_sel;
        logic              mem_rd_sel;
        logic              dm_read;
        logic              dm_write;
        logic              rf_write;
        logic              wb_data_sel;
        logic [1:0]        branch;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd_addr;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
    } ex_t;

    localparam logic [2:0] ALU_ADD = 3'b010;

    // A bubble is an ADD with every side effect disabled and all fields zero.
    function automatic ex_t bubble_f();
        ex_t b;
        b        = '0;
        b.alu_op = ALU_ADD;
        return b;
    endfunction

    ex_t              ex_q, ex_d, load_val;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             haz;

    // Load-use: the instruction in EXE is a load whose destination is read in ID.
    assign haz = ex_q.valid & ex_q.dm_read & (ex_q.rd_addr != '0) & bus.id_valid_i &
                 ((ex_q.rd_addr == bus.id_rs1_addr_i) | (ex_q.rd_addr == bus.id_rs2_addr_i));

    assign ld_use_stall_o = haz & ~flush_i & ~stall_i;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Capture the ID bundle; an empty slot is stripped of all side effects.
    always_comb begin
        load_val.valid       = bus.id_valid_i;
        load_val.alu_op      = bus.id_ALU_Ctrl_op_i;
        load_val.exe_pc_sel  = bus.id_EXE_pc_sel_i;
        load_val.alu_rs2_sel = bus.id_ALU_rs2_sel_i;
        load_val.mem_rd_sel  = bus.id_MEM_rd_sel_i;
        load_val.dm_read     = bus.id_DM_read_i & bus.id_valid_i;
        load_val.dm_write    = bus.id_DM_write_i & bus.id_valid_i;
        load_val.rf_write    = bus.id_reg_file_write_i & bus.id_valid_i;
        load_val.wb_data_sel = bus.id_WB_data_sel_i;
        load_val.branch      = bus.id_valid_i ? bus.id_branch_signal_i : 2'b00;
        load_val.pc          = bus.id_pc_i;
        load_val.rs1_data    = bus.id_rs1_data_i;
        load_val.rs2_data    = bus.id_rs2_data_i;
        load_val.imm         = bus.id_imm_i;
        load_val.rs1_addr    = bus.id_rs1_addr_i;
        load_val.rs2_addr    = bus.id_rs2_addr_i;
        load_val.rd_addr     = bus.id_rd_addr_i;
        load_val.funct3      = bus.id_funct3_i;
        load_val.funct7      = bus.id_funct7_i;
    end

    // Next state by priority: hold, flush, load-use bubble, load.
    always_comb begin
        // NOTE: defaults first so every path assigns ex_d/cnt_d and no latch is inferred.
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (stall_i) begin
            ex_d  = ex_q;
        end else if (flush_i) begin
            ex_d = bubble_f();
            if (bus.id_valid_i) cnt_d = cnt_inc;
        end else if (haz) begin
            ex_d  = bubble_f();
            cnt_d = cnt_inc;
        end else begin
            ex_d = load_val;
        end
    end

    // State registers; reset leaves a bubble in EXE and clears the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            ex_q  <= bubble_f();
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign bubble_cnt_o            = cnt_q;
    assign bus.ex_valid_o          = ex_q.valid;
    assign bus.ex_ALU_Ctrl_op_o    = ex_q.alu_op;
    assign bus.ex_EXE_pc_sel_o     = ex_q.exe_pc_sel;
    assign bus.ex_ALU_rs2_sel_o    = ex_q.alu_rs2_sel;
    assign bus.ex_MEM_rd_sel_o     = ex_q.mem_rd_sel;
    assign bus.ex_DM_read_o        = ex_q.dm_read;
    assign bus.ex_DM_write_o       = ex_q.dm_write;
    assign bus.ex_reg_file_write_o = ex_q.rf_write;
    assign bus.ex_WB_data_sel_o    = ex_q.wb_data_sel;
    assign bus.ex_branch_signal_o  = ex_q.branch;
    assign bus.ex_pc_o             = ex_q.pc;
    assign bus.ex_rs1_data_o       = ex_q.rs1_data;
    assign bus.ex_rs2_data_o       = ex_q.rs2_data;
    assign bus.ex_imm_o            = ex_q.imm;
    assign bus.ex_rs1_addr_o       = ex_q.rs1_addr;
    assign bus.ex_rs2_addr_o       = ex_q.rs2_addr;
    assign bus.ex_rd_addr_o        = ex_q.rd_addr;
    assign bus.ex_funct3_o         = ex_q.funct3;
    assign bus.ex_funct7_o         = ex_q.funct7;

endmodule

// File: tb/tb_id_exe_reg.sv
// Self-checking bench for id_exe_reg: vector table, directed corner cases,
// and randomized traffic against a rule-level reference model.
module tb_id_exe_reg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        valid;
        logic [2:0]  alu;
        logic        pc_sel;
        logic        rs2_sel;
        logic        mem_rd_sel;
        logic        dm_read;
        logic        dm_write;
        logic        rf_write;
        logic        wb_sel;
        logic [1:0]  br;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } fld_t;

    typedef struct {
        logic       valid;
        logic       dm_read;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       stall;
        logic       flush;
        logic       exp_ld_use;
        logic       exp_valid;
        logic [4:0] exp_rd;
        int         exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall_i = 1'b0;
    logic flush_i = 1'b0;
    logic ld_use_stall_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    int errors = 0;
    int checks = 0;

    fld_t m_ex;
    int   m_cnt;

    id_exe_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

    id_exe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .ld_use_stall_o (ld_use_stall_o),
        .bubble_cnt_o   (bubble_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [199:0] got, input logic [199:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic fld_t bubble();
        fld_t b;
        b     = '0;
        b.alu = 3'b010;
        return b;
    endfunction

    task automatic drive(input fld_t f);
        bus.id_valid_i          = f.valid;
        bus.id_ALU_Ctrl_op_i    = f.alu;
        bus.id_EXE_pc_sel_i     = f.pc_sel;
        bus.id_ALU_rs2_sel_i    = f.rs2_sel;
        bus.id_MEM_rd_sel_i     = f.mem_rd_sel;
        bus.id_DM_read_i        = f.dm_read;
        bus.id_DM_write_i       = f.dm_write;
        bus.id_reg_file_write_i = f.rf_write;
        bus.id_WB_data_sel_i    = f.wb_sel;
        bus.id_branch_signal_i  = f.br;
        bus.id_pc_i             = f.pc;
        bus.id_rs1_data_i       = f.rs1d;
        bus.id_rs2_data_i       = f.rs2d;
        bus.id_imm_i            = f.imm;
        bus.id_rs1_addr_i       = f.rs1a;
        bus.id_rs2_addr_i       = f.rs2a;
        bus.id_rd_addr_i        = f.rd;
        bus.id_funct3_i         = f.f3;
        bus.id_funct7_i         = f.f7;
    endtask

    function automatic fld_t sample();
        fld_t s;
        s.valid      = bus.ex_valid_o;
        s.alu        = bus.ex_ALU_Ctrl_op_o;
        s.pc_sel     = bus.ex_EXE_pc_sel_o;
        s.rs2_sel    = bus.ex_ALU_rs2_sel_o;
        s.mem_rd_sel = bus.ex_MEM_rd_sel_o;
        s.dm_read    = bus.ex_DM_read_o;
        s.dm_write   = bus.ex_DM_write_o;
        s.rf_write   = bus.ex_reg_file_write_o;
        s.wb_sel     = bus.ex_WB_data_sel_o;
        s.br         = bus.ex_branch_signal_o;
        s.pc         = bus.ex_pc_o;
        s.rs1d       = bus.ex_rs1_data_o;
        s.rs2d       = bus.ex_rs2_data_o;
        s.imm        = bus.ex_imm_o;
        s.rs1a       = bus.ex_rs1_addr_o;
        s.rs2a       = bus.ex_rs2_addr_o;
        s.rd         = bus.ex_rd_addr_o;
        s.f3         = bus.ex_funct3_o;
        s.f7         = bus.ex_funct7_o;
        return s;
    endfunction

    // Advance one clock; outputs are read 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pipeline rules stated directly, one cycle at a time.
    function automatic logic model_haz(input fld_t ex, input fld_t id);
        return ex.valid && ex.dm_read && ex.rd != 0 && id.valid &&
               (ex.rd == id.rs1a || ex.rd == id.rs2a);
    endfunction

    task automatic model_cycle(input fld_t id, input logic st, input logic fl);
        fld_t nxt;
        if (st) return;
        if (fl) begin
            if (id.valid) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            m_ex = bubble();
        end else if (model_haz(m_ex, id)) begin
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            m_ex  = bubble();
        end else begin
            nxt = id;
            if (!id.valid) begin
                nxt.rf_write = 1'b0;
                nxt.dm_read  = 1'b0;
                nxt.dm_write = 1'b0;
                nxt.br       = 2'b00;
            end
            m_ex = nxt;
        end
    endtask

    function automatic fld_t rand_fld();
        fld_t f;
        f          = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        f.valid    = ($urandom_range(0, 3) != 0);
        f.dm_read  = ($urandom_range(0, 1) != 0);
        f.rs1a     = 5'($urandom_range(0, 3));
        f.rs2a     = 5'($urandom_range(0, 3));
        f.rd       = 5'($urandom_range(0, 3));
        return f;
    endfunction

    vec_t vecs[14];
    fld_t f, exp_f;

    initial begin
        // valid dmr rd rs1 rs2 stall flush | ld_use ex_valid ex_rd cnt
        vecs[0]  = '{1, 1,  7, 1,  2, 0, 0, 0, 1,  7, 0}; // lw x7
        vecs[1]  = '{1, 0,  8, 3,  7, 0, 0, 1, 0,  0, 1}; // add uses x7 -> bubble
        vecs[2]  = '{1, 0,  8, 3,  7, 0, 0, 0, 1,  8, 1}; // held add now loads
        vecs[3]  = '{1, 1,  0, 0,  0, 0, 0, 0, 1,  0, 1}; // lw x0
        vecs[4]  = '{1, 0,  3, 0,  0, 0, 0, 0, 1,  3, 1}; // rs1=0 vs lw x0: no hazard
        vecs[5]  = '{1, 0,  4, 3,  0, 0, 0, 0, 1,  4, 1}; // add x3 in EXE: no hazard
        vecs[6]  = '{1, 1,  9, 1,  0, 0, 0, 0, 1,  9, 1}; // lw x9
        vecs[7]  = '{1, 0, 10, 9,  0, 0, 1, 0, 0,  0, 2}; // flush beats hazard
        vecs[8]  = '{1, 1, 11, 1,  0, 0, 0, 0, 1, 11, 2}; // lw x11
        vecs[9]  = '{1, 0, 12, 11, 0, 1, 1, 0, 1, 11, 2}; // stall beats flush: hold
        vecs[10] = '{1, 0, 12, 11, 0, 0, 1, 0, 0,  0, 3}; // stall released: bubble
        vecs[11] = '{0, 0,  5, 0,  0, 0, 1, 0, 0,  0, 3}; // flush of empty slot: not counted
        vecs[12] = '{0, 1,  6, 0,  0, 0, 0, 0, 0,  6, 3}; // empty slot loads, fields copied
        vecs[13] = '{1, 0,  1, 6,  0, 0, 0, 0, 1,  1, 3}; // invalid EXE never causes hazard

        drive('0);
        #12;
        check("reset_ex", 200'(sample()), 200'(bubble()));
        check("reset_cnt", 200'(bubble_cnt_o), 200'(0));
        rst_n = 1'b1;
        step();

        // Vector table.
        for (int i = 0; i < 14; i++) begin
            f          = '0;
            f.valid    = vecs[i].valid;
            f.dm_read  = vecs[i].dm_read;
            f.rf_write = 1'b1;
            f.alu      = 3'b001;
            f.rd       = vecs[i].rd;
            f.rs1a     = vecs[i].rs1;
            f.rs2a     = vecs[i].rs2;
            drive(f);
            stall_i = vecs[i].stall;
            flush_i = vecs[i].flush;
            #1;
            check($sformatf("vec%0d_ld_use", i), 200'(ld_use_stall_o), 200'(vecs[i].exp_ld_use));
            step();
            check($sformatf("vec%0d_valid", i), 200'(bus.ex_valid_o), 200'(vecs[i].exp_valid));
            check($sformatf("vec%0d_rd", i), 200'(bus.ex_rd_addr_o), 200'(vecs[i].exp_rd));
            check($sformatf("vec%0d_cnt", i), 200'(bubble_cnt_o), 200'(vecs[i].exp_cnt));
        end
        stall_i = 1'b0;
        flush_i = 1'b0;

        // Pass-through of a full bundle.
        f      = '0;
        f.valid = 1'b1; f.pc = 32'h0000_0100; f.imm = 32'hFFFF_FFF0; f.rd = 5'd5;
        f.alu  = 3'b001; f.rf_write = 1'b1; f.rs1d = 32'h1234_5678; f.rs2d = 32'hCAFE_F00D;
        f.rs1a = 5'd12; f.rs2a = 5'd13; f.f3 = 3'b101; f.f7 = 7'h20; f.br = 2'b10;
        f.pc_sel = 1'b1; f.wb_sel = 1'b1; f.mem_rd_sel = 1'b1; f.rs2_sel = 1'b1;
        drive(f);
        step();
        check("pass_through", 200'(sample()), 200'(f));

        // Asynchronous reset mid-cycle, no clock edge involved.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 200'(bus.ex_valid_o), 200'(0));
        check("async_rst_rfw", 200'(bus.ex_reg_file_write_o), 200'(0));
        check("async_rst_alu", 200'(bus.ex_ALU_Ctrl_op_o), 200'(3'b010));
        check("async_rst_cnt", 200'(bubble_cnt_o), 200'(0));
        rst_n = 1'b1;

        // Saturation: consecutive counted flush bubbles.
        f = '0;
        f.valid = 1'b1;
        drive(f);
        flush_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("sat%0d", i), 200'(bubble_cnt_o), 200'((i + 1 < CNT_MAX) ? i + 1 : CNT_MAX));
        end
        flush_i = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;

        // Randomized traffic against the model, with occasional resets.
        m_ex  = bubble();
        m_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            logic st, fl;
            if (c % 60 == 59) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
                m_ex  = bubble();
                m_cnt = 0;
            end
            f  = rand_fld();
            st = ($urandom_range(0, 7) == 0);
            fl = ($urandom_range(0, 7) == 0);
            drive(f);
            stall_i = st;
            flush_i = fl;
            #1;
            check($sformatf("rnd%0d_ld_use", c), 200'(ld_use_stall_o),
                  200'(model_haz(m_ex, f) && !st && !fl));
            model_cycle(f, st, fl);
            step();
            exp_f = m_ex;
            check($sformatf("rnd%0d_ex", c), 200'(sample()), 200'(exp_f));
            check($sformatf("rnd%0d_cnt", c), 200'(bubble_cnt_o), 200'(m_cnt));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
